sequence_player: RTL and testbench
==================================

Name: sequence_player

Overview:
- Plays back a stored Simon Says pattern as a timed series of arrow directions for the display and LED logic.
- Generalises the fixed four-step player with these parameters:
  - step count, direction width and on/gap timing;
  - per-round sequence length;
  - an explicit start/busy/done handshake;
  - an abort path.
- Sits between the game controller, which supplies the pattern and round length, and the arrow display driver.

Parameters:
- MAX_STEPS, 16, maximum number of steps in a pattern (>=1).
- DIR_W, 2, bits per arrow direction.
- ON_CYCLES, 25000000, clock cycles each arrow is shown (>=1).
- GAP_CYCLES, 12500000, blank clock cycles after each arrow (>=1).
- LEN_W, derived as clog2(MAX_STEPS+1); this is a localparam, not overridable.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin playback; sampled only in IDLE.
- abort  in  1  stop playback immediately with no done pulse.
- seq_len  in  LEN_W  number of steps to play this round.
- sequence  in  MAX_STEPS*DIR_W  pattern; step k is bits [k*DIR_W +: DIR_W].
- arrow_direction  out  DIR_W  direction of the current step.
- arrow_valid  out  1  high while a step is being shown.
- step_index  out  LEN_W  index of the step currently shown.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the last step's gap finishes.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; all outputs and internal counters are 0.
  - Release is synchronous to clock.
- Latching: on an accepted start, sequence and seq_len are captured into internal registers. Input changes during playback have no effect.
- Length clamp: a latched length greater than MAX_STEPS is treated as MAX_STEPS.
- IDLE:
  - If start=1 and seq_len>0: latch inputs, index=0, load timer with ON_CYCLES, go to SHOW.
  - If start=1 and seq_len=0: go to FINISH. No arrow is ever shown.
- SHOW:
  - arrow_valid=1.
  - arrow_direction = latched step[index], registered, and stable for the whole step.
  - step_index = index.
  - When the timer expires (exactly ON_CYCLES cycles in SHOW), load GAP_CYCLES and go to GAP.
- GAP:
  - arrow_valid=0; arrow_direction holds its last value.
  - On expiry after GAP_CYCLES cycles:
    - if index = len-1, go to FINISH;
    - otherwise index+1, load ON_CYCLES, go to SHOW.
- FINISH:
  - done=1 for exactly one cycle, then go to IDLE.
  - busy is still 1 during FINISH.
- Latency: start sampled at edge t → arrow_valid=1 and busy=1 visible after edge t.
- Total time from accepting start to the done pulse is len*(ON_CYCLES+GAP_CYCLES)+1 cycles.
- Ignored inputs:
  - start outside IDLE, including during FINISH.
  - start held high: after returning to IDLE it re-triggers one cycle after done. This is intentional; the controller must deassert start.
- abort:
  - In SHOW, GAP or FINISH: the next state is IDLE, arrow_valid=0, done=0, index=0.
  - abort beats timer expiry on the same cycle.
  - In IDLE, abort has priority over start, so start is ignored that cycle.
- Width rules:
  - Timer width is clog2(max(ON_CYCLES,GAP_CYCLES)+1).
  - index never exceeds MAX_STEPS-1, so it cannot wrap.
- Async reset mid-playback aborts instantly. done is not asserted.

Decomposition:
- Package simon_pkg holds:
  - direction constants DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3;
  - state encodings IDLE, SHOW, GAP, FINISH;
  - a clog2 helper function.
- One sub-module, step_timer (parameter WIDTH):
  - inputs: clock, reset_n, load, load_value;
  - output: expire, a one-cycle pulse when the down-count reaches 1.
- The FSM, index counter and output registers stay in sequence_player.

Test Plan (MAX_STEPS=4, DIR_W=2, ON_CYCLES=4, GAP_CYCLES=2):
- Basic run: sequence=8'b11_10_01_00, seq_len=4, start pulse →
  - arrow_direction 0,1,2,3, each with arrow_valid high for 4 cycles, separated by 2 low cycles;
  - step_index 0..3;
  - done pulses once, 25 cycles after the start edge;
  - busy then falls.
- Short round: seq_len=2 → only steps 0 and 1 are shown; done arrives 13 cycles after start.
- Zero and clamp:
  - seq_len=0 → done after 1 cycle, arrow_valid never high.
  - seq_len=7 → plays 4 steps, same timing as the basic run.
- Ignored inputs mid-play:
  - start re-pulsed during step 1 → no restart and no timing change.
  - sequence changed during step 1 → later steps still use the latched pattern.
- Abort: abort during the GAP after step 1 →
  - next cycle IDLE, busy=0, arrow_valid=0, no done pulse;
  - a new start then begins at step 0.
- Reset mid-run: reset_n low asynchronously during step 2 SHOW →
  - all outputs 0 immediately, with no clock edge needed;
  - after release, IDLE waits for start.

Source files
------------

// File: rtl/simon_pkg.sv
// simon_pkg: shared arrow directions, playback state encoding and width helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package simon_pkg;

  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW   = 2'd1,
    GAP    = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Bits needed to hold values 0 .. value-1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sequence_player_step_timer.sv
// step_timer: loadable down-counter that flags the last cycle of a programmed interval.
// Latency: expire is high in the load_value-th cycle after the load edge.
// Backpressure: none; a load always wins over counting.
module step_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  // Count down from the loaded value and park at zero so expire fires only once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expire = (count == WIDTH'(1));

endmodule

// File: rtl/sequence_player.sv
// sequence_player: shows a latched pattern one arrow at a time (SHOW for ON, blank GAP), then pulses done.
// Latency: arrow_valid/busy visible after the edge sampling start; done len*(ON+GAP)+1 cycles after that edge.
// Backpressure: none; start is only honoured in IDLE, abort returns to IDLE on the next edge.
module sequence_player
  import simon_pkg::*;
#(
  parameter int  MAX_STEPS  = 16,
  parameter int  DIR_W      = 2,
  parameter int  ON_CYCLES  = 25000000,
  parameter int  GAP_CYCLES = 12500000,
  localparam int LEN_W      = clog2(MAX_STEPS + 1)
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [LEN_W-1:0]           seq_len,
  input  logic [MAX_STEPS*DIR_W-1:0] seq_pattern,
  output logic [DIR_W-1:0]           arrow_direction,
  output logic                       arrow_valid,
  output logic [LEN_W-1:0]           step_index,
  output logic                       busy,
  output logic                       done
);

  localparam int               TIMER_W = clog2(max_int(ON_CYCLES, GAP_CYCLES) + 1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_STEPS);

  state_t                     state;
  state_t                     next_state;
  logic [MAX_STEPS*DIR_W-1:0] pattern_q;
  logic [LEN_W-1:0]           len_q;
  logic [LEN_W-1:0]           index_q;
  logic [LEN_W-1:0]           index_next;
  logic [DIR_W-1:0]           dir_q;
  logic                       accept;
  logic                       last_step;
  logic                       timer_load;
  logic [TIMER_W-1:0]         timer_value;
  logic                       timer_expire;

  // abort outranks start in IDLE, so a simultaneous pair does nothing.
  assign accept     = (state == IDLE) && start && !abort;
  assign last_step  = (index_q == len_q - LEN_W'(1));
  assign index_next = index_q + LEN_W'(1);

  step_timer #(
    .WIDTH(TIMER_W)
  ) u_step_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (timer_load),
    .load_value (timer_value),
    .expire     (timer_expire)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; abort beats a timer expiry in the same cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = (seq_len == '0) ? FINISH : SHOW;
        end
      end
      SHOW: begin
        if (abort) begin
          next_state = IDLE;
        end else if (timer_expire) begin
          next_state = GAP;
        end
      end
      GAP: begin
        if (abort) begin
          next_state = IDLE;
        end else if (timer_expire) begin
          next_state = last_step ? FINISH : SHOW;
        end
      end
      FINISH: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Outputs decoded from the current state, plus timer reload on every SHOW/GAP entry.
  always_comb begin
    arrow_valid = (state == SHOW);
    busy        = (state != IDLE);
    done        = (state == FINISH);
    timer_load  = (next_state != state) && ((next_state == SHOW) || (next_state == GAP));
    timer_value = (next_state == GAP) ? TIMER_W'(GAP_CYCLES) : TIMER_W'(ON_CYCLES);
  end

  // Latch the round on start; the shown direction is registered so it is stable for a whole step.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pattern_q <= '0;
      len_q     <= '0;
      index_q   <= '0;
      dir_q     <= '0;
    end else if (accept) begin
      pattern_q <= seq_pattern;
      len_q     <= (seq_len > MAX_LEN) ? MAX_LEN : seq_len;
      index_q   <= '0;
      if (seq_len != '0) begin
        dir_q <= seq_pattern[DIR_W-1:0];
      end
    end else if ((state == GAP) && (next_state == SHOW)) begin
      index_q <= index_next;
      dir_q   <= pattern_q[index_next*DIR_W +: DIR_W];
    end else if (next_state == IDLE) begin
      index_q <= '0;
    end
  end

  assign arrow_direction = dir_q;
  assign step_index      = index_q;

endmodule

// File: tb/tb_sequence_player.sv
// tb_sequence_player: scoreboard bench; stimulus queues expected display events, a monitor pops them.
// Latency: events are stamped with the clock edge after which they become visible.
// Backpressure: n/a.
module tb_sequence_player;

  localparam int MAX = 4;
  localparam int DW  = 2;
  localparam int ON  = 4;
  localparam int GAP = 2;
  localparam int PER = ON + GAP;
  localparam int LW  = 3;
  localparam int PW  = MAX * DW;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [LW-1:0] seq_len = '0;
  logic [PW-1:0] seq_pattern = '0;
  logic [DW-1:0] arrow_direction;
  logic          arrow_valid;
  logic [LW-1:0] step_index;
  logic          busy;
  logic          done;

  sequence_player #(
    .MAX_STEPS  (MAX),
    .DIR_W      (DW),
    .ON_CYCLES  (ON),
    .GAP_CYCLES (GAP)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .abort           (abort),
    .seq_len         (seq_len),
    .seq_pattern     (seq_pattern),
    .arrow_direction (arrow_direction),
    .arrow_valid     (arrow_valid),
    .step_index      (step_index),
    .busy            (busy),
    .done            (done)
  );

  always #5 clock = ~clock;

  // Edge counter: after posedge number N, cyc == N.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef enum int {EV_FALL = 0, EV_RISE = 1, EV_DONE = 2, EV_IDLE = 3} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       at;
    int       dir;
    int       idx;
    bit       stable;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  fails  = 0;

  function automatic void push_ev(input ev_kind_t kind, input int at, input int dir, input int idx);
    ev_t e;
    e.kind   = kind;
    e.at     = at;
    e.dir    = dir;
    e.idx    = idx;
    e.stable = 1'b1;
    exp_q.push_back(e);
  endfunction

  // Reference model: a round accepted at edge P shows step k over edges P+k*PER .. P+k*PER+ON,
  // done is high after edge P+len*PER (seen at the following edge), busy drops one edge later.
  function automatic void expect_round(input int p, input logic [PW-1:0] pat, input int len);
    int eff;
    int d;
    eff = (len > MAX) ? MAX : len;
    for (int k = 0; k < eff; k++) begin
      d = int'(pat[k*DW +: DW]);
      push_ev(EV_RISE, p + k*PER, d, k);
      push_ev(EV_FALL, p + k*PER + ON, d, k);
    end
    push_ev(EV_DONE, p + eff*PER, 0, 0);
    push_ev(EV_IDLE, p + eff*PER + 1, 0, 0);
  endfunction

  // Drop every expectation later than edge 'last' (playback cut short).
  function automatic void truncate(input int last);
    while (exp_q.size() > 0 && exp_q[exp_q.size()-1].at > last) begin
      void'(exp_q.pop_back());
    end
  endfunction

  function automatic void check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, got, want, cyc);
    end
  endfunction

  function automatic void observe(input ev_t got);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL event: got unexpected kind=%0d at=%0d dir=%0d idx=%0d, expected nothing",
               got.kind, got.at, got.dir, got.idx);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != got.kind || e.at != got.at || e.dir != got.dir ||
          e.idx != got.idx || e.stable != got.stable) begin
        fails++;
        $display("FAIL event: got kind=%0d at=%0d dir=%0d idx=%0d stable=%0d, expected kind=%0d at=%0d dir=%0d idx=%0d stable=%0d",
                 got.kind, got.at, got.dir, got.idx, got.stable,
                 e.kind, e.at, e.dir, e.idx, e.stable);
      end
    end
  endfunction

  // Monitor: turns output edges into events on the falling clock edge.
  initial begin
    bit   prev_valid;
    bit   prev_busy;
    ev_t  cur;
    ev_t  ev;
    prev_valid = 1'b0;
    prev_busy  = 1'b0;
    cur.kind = EV_RISE; cur.at = 0; cur.dir = 0; cur.idx = 0; cur.stable = 1'b1;
    forever begin
      @(negedge clock);
      if (prev_valid && !arrow_valid) begin
        ev = cur;
        ev.kind = EV_FALL;
        ev.at   = cyc;
        observe(ev);
      end
      if (!prev_valid && arrow_valid) begin
        cur.kind = EV_RISE; cur.at = cyc;
        cur.dir = int'(arrow_direction); cur.idx = int'(step_index); cur.stable = 1'b1;
        observe(cur);
      end else if (arrow_valid && (int'(arrow_direction) != cur.dir || int'(step_index) != cur.idx)) begin
        cur.stable = 1'b0;
      end
      if (done) begin
        ev.kind = EV_DONE; ev.at = cyc; ev.dir = 0; ev.idx = 0; ev.stable = 1'b1;
        observe(ev);
      end
      if (prev_busy && !busy) begin
        ev.kind = EV_IDLE; ev.at = cyc; ev.dir = 0; ev.idx = 0; ev.stable = 1'b1;
        observe(ev);
      end
      prev_valid = arrow_valid;
      prev_busy  = busy;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Present a start for one edge; P is the edge that samples it.
  task automatic launch(input logic [PW-1:0] pat, input int len, output int p);
    seq_pattern = pat;
    seq_len     = LW'(len);
    start       = 1'b1;
    p           = cyc + 1;
    expect_round(p, pat, len);
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) step(1);
    check_val({name, "_pending_events"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_zero_outputs(input string name);
    check_val({name, "_valid"}, int'(arrow_valid), 0);
    check_val({name, "_busy"}, int'(busy), 0);
    check_val({name, "_done"}, int'(done), 0);
    check_val({name, "_dir"}, int'(arrow_direction), 0);
    check_val({name, "_index"}, int'(step_index), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int            p;
    int            p2;
    int            len;
    int            eff;
    int            j;
    logic [PW-1:0] basic;
    logic [PW-1:0] pat;
    basic = 8'b11_10_01_00;

    #2;
    check_zero_outputs("reset");
    step(2);
    reset_n = 1'b1;
    step(2);

    // Basic run and short round.
    launch(basic, 4, p);
    wait_idle("basic");
    launch(PW'($urandom), 2, p);
    wait_idle("short");

    // Zero length and clamp.
    launch(PW'($urandom), 0, p);
    wait_idle("zero");
    launch(basic, 7, p);
    wait_idle("clamp");

    // start and pattern changes during step 1 are ignored.
    launch(basic, 4, p);
    step(6);
    start       = 1'b1;
    seq_pattern = ~basic;
    seq_len     = LW'(1);
    step(1);
    start = 1'b0;
    wait_idle("midplay");

    // Abort on the last GAP cycle after step 1, colliding with the timer expiry.
    launch(basic, 4, p);
    step(11);
    abort = 1'b1;
    truncate(p + 11);
    push_ev(EV_IDLE, p + 12, 0, 0);
    step(1);
    abort = 1'b0;
    wait_idle("abort");
    launch(PW'($urandom), 3, p);
    wait_idle("after_abort");

    // abort and start together in IDLE: start is dropped.
    seq_len = LW'(3);
    start   = 1'b1;
    abort   = 1'b1;
    step(1);
    start = 1'b0;
    abort = 1'b0;
    step(8);
    check_val("abort_idle_busy", int'(busy), 0);

    // Asynchronous reset during step 2 SHOW.
    launch(basic, 4, p);
    step(13);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    truncate(p + 12);
    push_ev(EV_FALL, p + 13, 2, 2);
    push_ev(EV_IDLE, p + 13, 0, 0);
    step(2);
    reset_n = 1'b1;
    step(6);
    check_val("post_reset_busy", int'(busy), 0);
    wait_idle("reset");
    launch(basic, 1, p);
    wait_idle("after_reset");

    // start held high re-triggers one edge after FINISH returns to IDLE.
    pat         = PW'($urandom);
    seq_pattern = pat;
    seq_len     = LW'(1);
    start       = 1'b1;
    p           = cyc + 1;
    p2          = p + PER + 2;
    expect_round(p, pat, 1);
    expect_round(p2, pat, 1);
    step(p2 - cyc);
    start = 1'b0;
    wait_idle("held_start");

    // Randomized rounds with ignored mid-play pokes.
    for (int r = 0; r < 25; r++) begin
      step($urandom_range(0, 3));
      len = $urandom_range(0, 7);
      eff = (len > MAX) ? MAX : len;
      launch(PW'($urandom), len, p);
      if (eff > 0 && $urandom_range(0, 1) == 1) begin
        j = $urandom_range(1, PER*eff - 1);
        step(j);
        start       = 1'b1;
        seq_pattern = PW'($urandom);
        seq_len     = LW'($urandom);
        step(1);
        start = 1'b0;
      end
      wait_idle("random");
    end

    step(4);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
